// File: rtl/seqdet_pkg.sv
// Shared types, default pattern constants and width helpers for the serial
// "10110" detector family.
package seqdet_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int                         PAT_W_DEFAULT = 5;
    localparam logic [PAT_W_DEFAULT-1:0]   PAT_DEFAULT   = 5'b10110;

    // Requester ID width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold a match count from 0 up to w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_matcher.sv
// Bit-serial pattern matcher. History is shifted MSB-first; a hit is only
// reported once PAT_W-1 bits have been seen since the last clear, so a
// pattern starting with zeros cannot hit against the cleared history.
module seq_matcher
    import seqdet_pkg::*;
#(
    parameter int               PAT_W = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT   = PAT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic z
);

    localparam int HW = PAT_W - 1;
    localparam int FW = $clog2(PAT_W);

    logic [HW-1:0] hist;
    logic [FW-1:0] fill;
    logic          full;

    assign full = (fill == FW'(HW));
    assign z    = en && full && ({hist, x} == PAT);

    // History shift register and saturating fill counter, cleared per word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= HW'({hist, x});
            if (!full) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seqdet_sched.sv
// Round-robin scheduler sharing one serial pattern matcher between NREQ
// requesters. A granted word is serialized MSB-first; per word the number
// of overlapping matches and the requester ID are reported with done.
module seqdet_sched
    import seqdet_pkg::*;
#(
    parameter int               NREQ   = 2,
    parameter int               WORD_W = 8,
    parameter int               PAT_W  = PAT_W_DEFAULT,
    parameter logic [PAT_W-1:0] PAT    = PAT_DEFAULT,
    parameter int               ID_W   = id_width(NREQ),
    parameter int               CNT_W  = cnt_width(WORD_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD_W-1:0]   word_i,
    output logic [NREQ-1:0]          ack,
    output logic                     busy,
    output logic                     x_o,
    output logic                     z_o,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [CNT_W-1:0]         match_cnt
);

    localparam int IDX_W = $clog2(WORD_W);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    rr;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               take;
    logic [WORD_W-1:0]  word_q;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               shifting;

    assign take     = (state == IDLE) && gnt_any;
    assign shifting = (state == SHIFT);
    assign last_bit = (idx == '0);
    assign busy     = (state != IDLE);
    assign done     = (state == REPORT);
    assign x_o      = shifting ? word_q[idx] : 1'b0;

    // Round-robin search: first requester at or after rr, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req[(int'(rr) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'((int'(rr) + i) % NREQ);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: one word per IDLE->SHIFT->REPORT pass.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any)  state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and result registers: grant, bit index, running count, outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack       <= '0;
            rr        <= '0;
            grant     <= '0;
            idx       <= '0;
            cnt       <= '0;
            done_id   <= '0;
            match_cnt <= '0;
        end else begin
            ack <= '0;
            if (take) begin
                ack   <= NREQ'(1) << gnt_idx;
                grant <= gnt_idx;
                idx   <= IDX_W'(WORD_W - 1);
                cnt   <= '0;
            end
            if (shifting) begin
                idx <= idx - 1'b1;
                cnt <= cnt + CNT_W'(z_o);
                if (last_bit) begin
                    done_id   <= grant;
                    match_cnt <= cnt + CNT_W'(z_o);
                end
            end
            if (state == REPORT) begin
                rr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // Word latch; data only, captured at the grant edge.
    always_ff @(posedge clk) begin
        if (take) word_q <= word_i[gnt_idx*WORD_W +: WORD_W];
    end

    seq_matcher #(
        .PAT_W (PAT_W),
        .PAT   (PAT)
    ) u_matcher (
        .clk (clk),
        .rst (rst),
        .clr (!shifting),
        .en  (shifting),
        .x   (x_o),
        .z   (z_o)
    );

endmodule
